// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus of the program-loader encoder.
// The slave modport is the encoder; the master side feeds requests and observes writes.
interface instr_encoder_if #(
   parameter int unsigned ADDR_W = 6
) ();
   logic              InValid;
   logic              InReady;
   logic [3:0]        Mnem;
   logic [4:0]        Rs;
   logic [4:0]        Rt;
   logic [4:0]        Rd;
   logic [15:0]       Imm;
   logic [25:0]       Target;
   logic              MemWE;
   logic [ADDR_W-1:0] MemAddr;
   logic [31:0]       MemData;

   modport master (
      output InValid, Mnem, Rs, Rt, Rd, Imm, Target,
      input  InReady, MemWE, MemAddr, MemData
   );

   modport slave (
      input  InValid, Mnem, Rs, Rt, Rd, Imm, Target,
      output InReady, MemWE, MemAddr, MemData
   );
endinterface

// File: rtl/instr_encoder.sv
// Encodes compact instruction requests into MIPS words and writes them sequentially
// into instruction memory, one word per two cycles at most.
module instr_encoder #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DEPTH  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Clear,
   instr_encoder_if.slave    bus,
   output logic [ADDR_W:0]   Count,
   output logic              Full,
   output logic              Error
);

   localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {StIdle, StWrite, StFull} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [31:0]       data_q, data_d;
   logic              error_q, error_d;

   logic [31:0]       word;
   logic              legal;
   logic [5:0]        funct;
   logic [5:0]        op;
   logic [ADDR_W:0]   count_inc;

   // Word encoder; fields pass through untouched, Rd only reaches R-type words.
   always_comb begin
      legal = 1'b1;
      funct = 6'b000000;
      op    = 6'b000000;
      word  = 32'h0;
      case (bus.Mnem)
         4'd0:    funct = 6'b100000;
         4'd1:    funct = 6'b100010;
         4'd2:    funct = 6'b100100;
         4'd3:    funct = 6'b100101;
         4'd4:    funct = 6'b100111;
         4'd5:    funct = 6'b101010;
         4'd6:    op    = 6'b001000;
         4'd7:    op    = 6'b100011;
         4'd8:    op    = 6'b101011;
         4'd9:    op    = 6'b000100;
         4'd10:   op    = 6'b000010;
         default: legal = 1'b0;
      endcase
      if (bus.Mnem <= 4'd5) begin
         word = {6'b000000, bus.Rs, bus.Rt, bus.Rd, 5'b00000, funct};
      end else if (bus.Mnem == 4'd10) begin
         word = {op, bus.Target};
      end else begin
         word = {op, bus.Rs, bus.Rt, bus.Imm};
      end
   end

   assign count_inc = count_q + 1'b1;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      data_d  = data_q;
      error_d = error_q;
      if (Clear) begin
         state_d = StIdle;
         count_d = '0;
         error_d = 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.InValid) begin
                  if (legal) begin
                     data_d  = word;
                     state_d = StWrite;
                  end else begin
                     error_d = 1'b1;
                  end
               end
            end
            StWrite: begin
               count_d = count_inc;
               state_d = (count_inc == DepthW) ? StFull : StIdle;
            end
            default: state_d = StFull;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         count_q <= '0;
         data_q  <= 32'h0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         data_q  <= data_d;
         error_q <= error_d;
      end
   end

   // Clear wins over a same-cycle request and cancels the write pulse outright.
   assign bus.InReady = (state_q == StIdle) && !Clear;
   assign bus.MemWE   = (state_q == StWrite) && !Clear;
   assign bus.MemAddr = count_q[ADDR_W-1:0];
   assign bus.MemData = data_q;
   assign Count       = count_q;
   assign Full        = (count_q == DepthW);
   assign Error       = error_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed requests, a cycle-level reference model checked
// on every falling edge, and literal checks on the captured write log.
module tb_instr_encoder;
   localparam int unsigned AW    = 6;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          Clear;
   logic [AW:0]   count_o;
   logic          full_o;
   logic          error_o;

   instr_encoder_if #(.ADDR_W(AW)) bus ();

   instr_encoder #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .Clear (Clear),
      .bus   (bus),
      .Count (count_o),
      .Full  (full_o),
      .Error (error_o)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_encode(int unsigned mn, int unsigned rs, int unsigned rt,
                                                int unsigned rd, int unsigned imm,
                                                int unsigned tgt);
      int unsigned functs[6] = '{32, 34, 36, 37, 39, 42};
      int unsigned opcs[4]   = '{8, 35, 43, 4};
      longint unsigned w;
      if (mn < 6)       w = rs * 2097152 + rt * 65536 + rd * 2048 + functs[mn];
      else if (mn < 10) w = opcs[mn-6] * 67108864 + rs * 2097152 + rt * 65536 + imm;
      else              w = 2 * 67108864 + tgt;
      return w[31:0];
   endfunction

   // Reference model: what the outputs must read in the cycle after each edge.
   int          m_count;
   bit          m_err, m_pending, started;
   logic [31:0] m_data;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_count   <= 0;
         m_err     <= 1'b0;
         m_pending <= 1'b0;
         m_data    <= 32'h0;
         started   <= 1'b1;
      end else if (Clear) begin
         m_count   <= 0;
         m_err     <= 1'b0;
         m_pending <= 1'b0;
      end else if (m_pending) begin
         m_count   <= m_count + 1;
         m_pending <= 1'b0;
      end else if (m_count != DEPTH && bus.InValid) begin
         if (bus.Mnem <= 4'd10) begin
            m_pending <= 1'b1;
            m_data    <= model_encode(bus.Mnem, bus.Rs, bus.Rt, bus.Rd, bus.Imm, bus.Target);
         end else begin
            m_err <= 1'b1;
         end
      end
   end

   logic [31:0] wr_data[$];
   int          wr_addr[$];

   always @(negedge clk) begin
      if (started) begin
         check("in_ready", bus.InReady, !m_pending && m_count != DEPTH && !Clear);
         check("mem_we", bus.MemWE, m_pending && !Clear);
         check("mem_addr", bus.MemAddr, m_count % 64);
         check("mem_data", bus.MemData, m_data);
         check("count", count_o, m_count);
         check("full", full_o, m_count == DEPTH);
         check("error", error_o, m_err);
         if (bus.MemWE === 1'b1) begin
            wr_data.push_back(bus.MemData);
            wr_addr.push_back(int'(bus.MemAddr));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(int unsigned mn, int unsigned rs, int unsigned rt, int unsigned rd,
                       int unsigned imm, int unsigned tgt, int budget, bit keep, output bit acc);
      bus.Mnem    = mn[3:0];
      bus.Rs      = rs[4:0];
      bus.Rt      = rt[4:0];
      bus.Rd      = rd[4:0];
      bus.Imm     = imm[15:0];
      bus.Target  = tgt[25:0];
      bus.InValid = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.InReady === 1'b1) acc = 1'b1;
         tick();
         if (acc) break;
      end
      if (!keep) bus.InValid = 1'b0;
   endtask

   task automatic do_clear();
      Clear = 1'b1;
      tick();
      Clear = 1'b0;
   endtask

   bit acc;
   int base;

   initial begin
      rst_n = 1'b0;
      Clear = 1'b0;
      bus.InValid = 1'b0;
      bus.Mnem = '0; bus.Rs = '0; bus.Rt = '0; bus.Rd = '0; bus.Imm = '0; bus.Target = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      check("enc_add_lit", model_encode(0, 9, 10, 8, 0, 0), 32'h012A4020);
      check("enc_lw_lit", model_encode(7, 29, 8, 0, 4, 0), 32'h8FA80004);
      check("enc_j_lit", model_encode(10, 0, 0, 0, 0, 'h10), 32'h08000010);

      // Single ADD
      base = wr_data.size();
      send(0, 9, 10, 8, 0, 0, 10, 1'b0, acc);
      check("add_accept", acc, 1);
      tick(); tick();
      check("add_nwr", wr_data.size() - base, 1);
      check("add_data", wr_data[base], 32'h012A4020);
      check("add_addr", wr_addr[base], 0);
      check("add_count", count_o, 1);
      do_clear();

      // Back-to-back with InValid held high
      base = wr_data.size();
      send(7, 29, 8, 0, 'h0004, 0, 10, 1'b1, acc);  check("b2b_acc0", acc, 1);
      send(8, 29, 9, 0, 'h0008, 0, 10, 1'b1, acc);  check("b2b_acc1", acc, 1);
      send(9, 8, 0, 0, 'hFFFF, 0, 10, 1'b1, acc);   check("b2b_acc2", acc, 1);
      send(10, 0, 0, 0, 0, 'h10, 10, 1'b0, acc);    check("b2b_acc3", acc, 1);
      tick(); tick();
      check("b2b_nwr", wr_data.size() - base, 4);
      check("b2b_d0", wr_data[base],   32'h8FA80004);
      check("b2b_d1", wr_data[base+1], 32'hAFA90008);
      check("b2b_d2", wr_data[base+2], 32'h1100FFFF);
      check("b2b_d3", wr_data[base+3], 32'h08000010);
      for (int i = 0; i < 4; i++) check("b2b_addr", wr_addr[base+i], i);
      check("full_set", full_o, 1);

      // Fifth request while full is never consumed
      send(6, 1, 2, 0, 'h1234, 0, 6, 1'b0, acc);
      check("full_no_accept", acc, 0);
      check("full_nwr", wr_data.size() - base, 4);
      do_clear();
      check("clr_count", count_o, 0);
      base = wr_data.size();
      send(6, 1, 2, 0, 'h1234, 0, 10, 1'b0, acc);
      tick(); tick();
      check("post_clr_addr", wr_addr[base], 0);
      check("post_clr_data", wr_data[base], 32'h20221234);

      // Illegal mnemonic
      do_clear();
      base = wr_data.size();
      send(12, 3, 4, 5, 'h55, 0, 10, 1'b0, acc);
      check("ill_accept", acc, 1);
      tick(); tick();
      check("ill_nwr", wr_data.size() - base, 0);
      check("ill_err", error_o, 1);
      send(6, 2, 3, 0, 'hFFF0, 0, 10, 1'b0, acc);
      tick(); tick();
      check("ill_err_sticky", error_o, 1);
      check("ill_addi_data", wr_data[base], 32'h2043FFF0);
      do_clear();
      check("ill_err_clr", error_o, 0);

      // Clear and InValid together: request dropped
      base = wr_data.size();
      bus.Mnem = 4'd0; bus.InValid = 1'b1; Clear = 1'b1;
      tick();
      Clear = 1'b0; bus.InValid = 1'b0;
      tick(); tick();
      check("clr_vs_valid_nwr", wr_data.size() - base, 0);

      // Clear during the WRITE cycle
      send(1, 1, 2, 3, 0, 0, 10, 1'b0, acc);
      Clear = 1'b1;
      @(negedge clk);
      check("clr_wr_we", bus.MemWE, 0);
      tick();
      Clear = 1'b0;
      check("clr_wr_count", count_o, 0);

      // Reset during the WRITE cycle
      send(4, 7, 7, 7, 0, 0, 10, 1'b0, acc);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("rst_wr_count", count_o, 0);
      check("rst_wr_data", bus.MemData, 0);
      check("rst_wr_we", bus.MemWE, 0);
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
